// File: rtl/ip_tx_pkg.sv
// Shared definitions for the IP transmit arbiter: FSM encoding, port
// indices and bit positions of the fields inside the user sideband
// {len[55:40], flags[39:37], type[36:29], offset[28:16], ID[15:0]}.
package ip_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_P0 = 2'd1,
        ST_GRANT_P1 = 2'd2
    } arb_state_t;

    localparam logic PORT_P0 = 1'b0;   // UDP requester
    localparam logic PORT_P1 = 1'b1;   // ICMP requester

    localparam int USER_LEN_HI   = 55;
    localparam int USER_LEN_LO   = 40;
    localparam int USER_FLAGS_HI = 39;
    localparam int USER_FLAGS_LO = 37;
    localparam int USER_ID_HI    = 15;
    localparam int USER_ID_LO    = 0;

    // Map a port index onto the FSM state that grants it.
    function automatic arb_state_t grant_state(input logic port);
        return (port == PORT_P1) ? ST_GRANT_P1 : ST_GRANT_P0;
    endfunction

endpackage

// File: rtl/ip_tx_arb_outreg.sv
// Single-stage AXI-Stream output register. A beat is loaded whenever the
// caller signals an input transfer (i_load); o_accept tells the caller when
// the stage can take a beat (empty, or draining this cycle). A 1-bit source
// tag travels with each beat so the owner can attribute output transfers.
module ip_tx_arb_outreg #(
    parameter int P_USER_W = 56
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [63:0]         i_data,
    input  logic [P_USER_W-1:0] i_user,
    input  logic [7:0]          i_keep,
    input  logic                i_last,
    input  logic                i_src,
    output logic                o_accept,
    output logic [63:0]         o_data,
    output logic [P_USER_W-1:0] o_user,
    output logic [7:0]          o_keep,
    output logic                o_last,
    output logic                o_src,
    output logic                o_valid,
    input  logic                i_ready
);

    // Accept a new beat when empty or when the held beat leaves this cycle.
    always_comb begin
        o_accept = !o_valid || i_ready;
    end

    // Load on input transfer; drop valid only when the held beat drains
    // without a replacement. Nothing changes while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_user  <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
            o_src   <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_data  <= i_data;
            o_user  <= i_user;
            o_keep  <= i_keep;
            o_last  <= i_last;
            o_src   <= i_src;
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Two-requester packet arbiter feeding the IP transmit path. Whole packets
// are granted (no mid-packet switching); ties are broken round-robin, or
// in favour of port 1 (ICMP) when IP_TX_ARB_STRICT_PRIO_EN is defined.
// Handshake: a beat moves on any AXIS port only in a cycle where valid and
// ready are both high; ready never depends on the same port's valid.
module ip_tx_arbiter
    import ip_tx_pkg::*;
#(
    parameter int P_USER_W = 56,
    parameter int P_CNT_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [63:0]         s_axis_p0_data,
    input  logic [P_USER_W-1:0] s_axis_p0_user,
    input  logic [7:0]          s_axis_p0_keep,
    input  logic                s_axis_p0_last,
    input  logic                s_axis_p0_valid,
    output logic                s_axis_p0_ready,
    input  logic [63:0]         s_axis_p1_data,
    input  logic [P_USER_W-1:0] s_axis_p1_user,
    input  logic [7:0]          s_axis_p1_keep,
    input  logic                s_axis_p1_last,
    input  logic                s_axis_p1_valid,
    output logic                s_axis_p1_ready,
    output logic [63:0]         m_axis_ip_data,
    output logic [P_USER_W-1:0] m_axis_ip_user,
    output logic [7:0]          m_axis_ip_keep,
    output logic                m_axis_ip_last,
    output logic                m_axis_ip_valid,
    input  logic                m_axis_ip_ready,
    output logic [P_CNT_W-1:0]  o_pkt_cnt_p0,
    output logic [P_CNT_W-1:0]  o_pkt_cnt_p1,
    output logic                o_busy
);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic                r_last_grant;
    logic                r_rst_done;   // blocks grants on the first edge after reset release
    logic                tie_winner;
    logic                out_accept;
    logic                out_src;
    logic                in_load;
    logic                in_src;
    logic [63:0]         in_data;
    logic [P_USER_W-1:0] in_user;
    logic [7:0]          in_keep;
    logic                in_last;

`ifdef IP_TX_ARB_STRICT_PRIO_EN
    // ICMP always wins a tie; round-robin history is not consulted.
    assign tie_winner = PORT_P1;
`else
    // Round-robin: on a tie, the port not granted most recently wins.
    assign tie_winner = ~r_last_grant;
`endif

    // State register, grant history and post-reset qualifier.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            r_last_grant <= PORT_P1;
            r_rst_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_rst_done <= 1'b1;
            if (state_q == ST_IDLE && state_d != ST_IDLE) begin
                r_last_grant <= (state_d == ST_GRANT_P1);
            end
        end
    end

    // Next state: grant from IDLE, release after the last beat is captured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (r_rst_done) begin
                    if (s_axis_p0_valid && s_axis_p1_valid) begin
                        state_d = grant_state(tie_winner);
                    end else if (s_axis_p0_valid) begin
                        state_d = ST_GRANT_P0;
                    end else if (s_axis_p1_valid) begin
                        state_d = ST_GRANT_P1;
                    end
                end
            end
            ST_GRANT_P0: begin
                if (s_axis_p0_valid && s_axis_p0_ready && s_axis_p0_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT_P1: begin
                if (s_axis_p1_valid && s_axis_p1_ready && s_axis_p1_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs from state: per-port ready, input mux and busy flag.
    always_comb begin
        s_axis_p0_ready = (state_q == ST_GRANT_P0) && out_accept;
        s_axis_p1_ready = (state_q == ST_GRANT_P1) && out_accept;
        in_src          = (state_q == ST_GRANT_P1);
        in_load         = (s_axis_p0_valid && s_axis_p0_ready) ||
                          (s_axis_p1_valid && s_axis_p1_ready);
        in_data         = in_src ? s_axis_p1_data : s_axis_p0_data;
        in_user         = in_src ? s_axis_p1_user : s_axis_p0_user;
        in_keep         = in_src ? s_axis_p1_keep : s_axis_p0_keep;
        in_last         = in_src ? s_axis_p1_last : s_axis_p0_last;
        o_busy          = (state_q != ST_IDLE);
    end

    ip_tx_arb_outreg #(
        .P_USER_W (P_USER_W)
    ) u_outreg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (in_load),
        .i_data   (in_data),
        .i_user   (in_user),
        .i_keep   (in_keep),
        .i_last   (in_last),
        .i_src    (in_src),
        .o_accept (out_accept),
        .o_data   (m_axis_ip_data),
        .o_user   (m_axis_ip_user),
        .o_keep   (m_axis_ip_keep),
        .o_last   (m_axis_ip_last),
        .o_src    (out_src),
        .o_valid  (m_axis_ip_valid),
        .i_ready  (m_axis_ip_ready)
    );

    // Count packets as their last beat leaves on the output; wraps freely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pkt_cnt_p0 <= '0;
            o_pkt_cnt_p1 <= '0;
        end else if (m_axis_ip_valid && m_axis_ip_ready && m_axis_ip_last) begin
            if (out_src == PORT_P1) begin
                o_pkt_cnt_p1 <= o_pkt_cnt_p1 + 1'b1;
            end else begin
                o_pkt_cnt_p0 <= o_pkt_cnt_p0 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter. Counters are built 4 bits wide so the
// wrap case stays short. Tie-order expectations follow IP_TX_ARB_STRICT_PRIO_EN.
module tb_ip_tx_arbiter;

    localparam int UW = 56;
    localparam int CW = 4;
    localparam int BW = UW + 8 + 1 + 64;

    logic          clk;
    logic          rst_n;
    logic [63:0]   p0_data, p1_data, m_data;
    logic [UW-1:0] p0_user, p1_user, m_user;
    logic [7:0]    p0_keep, p1_keep, m_keep;
    logic          p0_last, p1_last, m_last;
    logic          p0_valid, p1_valid, m_valid;
    logic          p0_ready, p1_ready, m_ready;
    logic [CW-1:0] cnt_p0, cnt_p1;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int drv_busy [2];
    logic [BW-1:0] mon_q[$];
    logic [BW-1:0] obs_beat;

    assign obs_beat = {m_user, m_keep, m_last, m_data};

    ip_tx_arbiter #(.P_USER_W(UW), .P_CNT_W(CW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .s_axis_p0_data  (p0_data),
        .s_axis_p0_user  (p0_user),
        .s_axis_p0_keep  (p0_keep),
        .s_axis_p0_last  (p0_last),
        .s_axis_p0_valid (p0_valid),
        .s_axis_p0_ready (p0_ready),
        .s_axis_p1_data  (p1_data),
        .s_axis_p1_user  (p1_user),
        .s_axis_p1_keep  (p1_keep),
        .s_axis_p1_last  (p1_last),
        .s_axis_p1_valid (p1_valid),
        .s_axis_p1_ready (p1_ready),
        .m_axis_ip_data  (m_data),
        .m_axis_ip_user  (m_user),
        .m_axis_ip_keep  (m_keep),
        .m_axis_ip_last  (m_last),
        .m_axis_ip_valid (m_valid),
        .m_axis_ip_ready (m_ready),
        .o_pkt_cnt_p0    (cnt_p0),
        .o_pkt_cnt_p1    (cnt_p1),
        .o_busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Output monitor: records every beat that will transfer at the next edge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) mon_q.push_back(obs_beat);
    end

    function automatic logic [63:0] mk_data(input int port, input int pkt, input int beat);
        return 64'hA5A5_0000_0000_0000 | (64'(port) << 16) | (64'(pkt) << 8) | 64'(beat);
    endfunction

    function automatic logic [UW-1:0] mk_user(input int port, input int pkt, input int n);
        return {16'(n * 8), 3'b101, 8'h11, 13'h0AB, 8'(port), 8'(pkt)};
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int port, input int pkt, input int beat, input int n);
        logic lst;
        lst = (beat == n - 1);
        return {mk_user(port, pkt, n), (lst ? 8'h0F : 8'hFF), lst, mk_data(port, pkt, beat)};
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int port, input logic v, input logic [63:0] d,
                            input logic [UW-1:0] u, input logic l);
        if (port == 0) begin
            p0_valid = v; p0_data = d; p0_user = u; p0_last = l; p0_keep = l ? 8'h0F : 8'hFF;
        end else begin
            p1_valid = v; p1_data = d; p1_user = u; p1_last = l; p1_keep = l ? 8'h0F : 8'hFF;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one packet; abandons it if reset is asserted while waiting.
    task automatic drive_pkt(input int port, input int pkt, input int nbeats);
        int guard;
        drv_busy[port] = 1;
        for (int b = 0; b < nbeats; b++) begin
            set_beat(port, 1'b1, mk_data(port, pkt, b), mk_user(port, pkt, nbeats), (b == nbeats - 1));
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!(port == 0 ? p0_ready : p1_ready) && rst_n && guard < 200);
            chk("drv_timeout", BW'(guard >= 200), '0);
            if (!rst_n || guard >= 200) begin
                set_beat(port, 1'b0, '0, '0, 1'b0);
                drv_busy[port] = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
        set_beat(port, 1'b0, '0, '0, 1'b0);
        drv_busy[port] = 0;
    endtask

    task automatic wait_drv_idle(input int port, input string tag);
        int guard;
        guard = 0;
        while (drv_busy[port] != 0 && guard < 300) begin
            tick();
            guard++;
        end
        chk(tag, BW'(drv_busy[port]), '0);
    endtask

    initial begin
        int guard;
        drv_busy[0] = 0;
        drv_busy[1] = 0;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        set_beat(0, 1'b0, '0, '0, 1'b0);
        set_beat(1, 1'b0, '0, '0, 1'b0);
        #1 rst_n = 1'b0;

        // ---- A: reset values, single 3-beat packet, exact latency ----
        repeat (3) @(posedge clk);
        #1;
        chk("A_rst_beat",  obs_beat, '0);
        chk("A_rst_valid", BW'(m_valid), '0);
        chk("A_rst_ready", BW'({p0_ready, p1_ready}), '0);
        chk("A_rst_busy",  BW'(busy), '0);
        chk("A_rst_cnt",   BW'({cnt_p0, cnt_p1}), '0);
        set_beat(0, 1'b1, mk_data(0, 0, 0), mk_user(0, 0, 3), 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("A_e1_busy",  BW'(busy), '0);
        chk("A_e1_ready", BW'(p0_ready), '0);
        tick();
        chk("A_e2_busy",  BW'(busy), 1);
        chk("A_e2_ready", BW'({p0_ready, p1_ready}), BW'(2'b10));
        chk("A_e2_valid", BW'(m_valid), '0);
        tick();
        chk("A_beat0", obs_beat, exp_beat(0, 0, 0, 3));
        chk("A_valid0", BW'(m_valid), 1);
        set_beat(0, 1'b1, mk_data(0, 0, 1), mk_user(0, 0, 3), 1'b0);
        tick();
        chk("A_beat1", obs_beat, exp_beat(0, 0, 1, 3));
        set_beat(0, 1'b1, mk_data(0, 0, 2), mk_user(0, 0, 3), 1'b1);
        tick();
        chk("A_beat2", obs_beat, exp_beat(0, 0, 2, 3));
        chk("A_idle_after_last", BW'(busy), '0);
        chk("A_cnt_before_out", BW'(cnt_p0), '0);
        set_beat(0, 1'b0, '0, '0, 1'b0);
        tick();
        chk("A_valid_drop", BW'(m_valid), '0);
        chk("A_cnt_p0", BW'(cnt_p0), 1);

        // ---- B: output stalled for 5 cycles mid-packet ----
        mon_q.delete();
        fork
            drive_pkt(0, 1, 4);
        join_none
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!m_valid && guard < 20);
        chk("B_first_valid", BW'(m_valid), 1);
        chk("B_first_beat", obs_beat, exp_beat(0, 1, 0, 4));
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("B_hold_beat", obs_beat, exp_beat(0, 1, 0, 4));
            chk("B_hold_valid", BW'(m_valid), 1);
            chk("B_hold_ready", BW'(p0_ready), '0);
        end
        m_ready = 1'b1;
        wait_drv_idle(0, "B_drv_done");
        repeat (3) tick();
        chk("B_beat_count", BW'(mon_q.size()), 4);
        for (int i = 0; i < 4 && i < mon_q.size(); i++) chk("B_beat", mon_q[i], exp_beat(0, 1, i, 4));
        chk("B_cnt_p0", BW'(cnt_p0), 2);

        // ---- C: both ports requesting from reset release ----
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        mon_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fork
            begin
                drive_pkt(0, 1, 2);
                drive_pkt(0, 2, 2);
            end
            begin
                drive_pkt(1, 1, 2);
                drive_pkt(1, 2, 2);
            end
        join
        repeat (3) tick();
        chk("C_beat_count", BW'(mon_q.size()), 8);
        if (mon_q.size() == 8) begin
`ifdef IP_TX_ARB_STRICT_PRIO_EN
            chk("C_seq0", mon_q[0], exp_beat(1, 1, 0, 2));
            chk("C_seq1", mon_q[1], exp_beat(1, 1, 1, 2));
            chk("C_seq2", mon_q[2], exp_beat(1, 2, 0, 2));
            chk("C_seq3", mon_q[3], exp_beat(1, 2, 1, 2));
            chk("C_seq4", mon_q[4], exp_beat(0, 1, 0, 2));
            chk("C_seq5", mon_q[5], exp_beat(0, 1, 1, 2));
            chk("C_seq6", mon_q[6], exp_beat(0, 2, 0, 2));
            chk("C_seq7", mon_q[7], exp_beat(0, 2, 1, 2));
`else
            chk("C_seq0", mon_q[0], exp_beat(0, 1, 0, 2));
            chk("C_seq1", mon_q[1], exp_beat(0, 1, 1, 2));
            chk("C_seq2", mon_q[2], exp_beat(1, 1, 0, 2));
            chk("C_seq3", mon_q[3], exp_beat(1, 1, 1, 2));
            chk("C_seq4", mon_q[4], exp_beat(0, 2, 0, 2));
            chk("C_seq5", mon_q[5], exp_beat(0, 2, 1, 2));
            chk("C_seq6", mon_q[6], exp_beat(1, 2, 0, 2));
            chk("C_seq7", mon_q[7], exp_beat(1, 2, 1, 2));
`endif
        end
        chk("C_cnt", BW'({cnt_p0, cnt_p1}), BW'({4'd2, 4'd2}));

        // ---- D: reset during beat 2 of a 4-beat packet ----
        fork
            drive_pkt(0, 7, 4);
        join_none
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!m_valid && guard < 20);
        tick();
        chk("D_pre_beat1", obs_beat, exp_beat(0, 7, 1, 4));
        rst_n = 1'b0;
        #1;
        chk("D_rst_beat",  obs_beat, '0);
        chk("D_rst_valid", BW'(m_valid), '0);
        chk("D_rst_ready", BW'({p0_ready, p1_ready}), '0);
        chk("D_rst_busy",  BW'(busy), '0);
        chk("D_rst_cnt",   BW'({cnt_p0, cnt_p1}), '0);
        wait_drv_idle(0, "D_drv_abort");
        mon_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("D_no_partial", BW'(mon_q.size()), '0);
        chk("D_idle_valid", BW'(m_valid), '0);
        chk("D_idle_busy", BW'(busy), '0);

        // ---- E: 2^CW+1 single-beat packets on port 1, counter wraps ----
        mon_q.delete();
        for (int i = 1; i <= 17; i++) begin
            drive_pkt(1, i, 1);
            repeat (2) tick();
            if (i == 15) chk("E_cnt_max", BW'(cnt_p1), BW'(4'hF));
            if (i == 16) chk("E_cnt_wrap0", BW'(cnt_p1), '0);
        end
        chk("E_cnt_wrap1", BW'(cnt_p1), 1);
        chk("E_cnt_p0", BW'(cnt_p0), '0);
        chk("E_beat_count", BW'(mon_q.size()), 17);
        if (mon_q.size() == 17) chk("E_last_beat", mon_q[16], exp_beat(1, 17, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
